ccm_port_arb: RTL and testbench

//  Shares the single-port 32x64K CCM between the LSU (load/store) and the IFU (fetch, read-only).

---
 rtl/ccm_port_arb.sv | 168 ++++++++++++++++
 tb/tb_ccm_port_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccm_port_arb.sv
// Single-port CCM arbiter: LSU/IFU grant with IFU starvation guard, byte-to-word
// address conversion, and one-cycle-later aligned/extended load responses.
module ccm_port_arb #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_rdata,
  output logic        lsu_rsp_err,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rsp_rdata,
  output logic        ifu_rsp_err,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_d,
  output logic        mem_we,
  output logic [1:0]  mem_store_type,
  output logic [1:0]  mem_store_offset,
  input  logic [31:0] mem_q
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [31:0]      r_mem_adr;
  logic [31:0]      r_mem_d;
  logic [1:0]       r_mem_st_type;
  logic [1:0]       r_mem_st_off;

  logic             r_rsp_pend;
  logic             r_rsp_own;
  logic             r_rsp_err;
  logic [1:0]       r_ld_size;
  logic             r_ld_uns;
  logic [1:0]       r_ld_off;
  logic             r_rsp_st;

  logic             w_lsu_err;
  logic             w_ifu_err;
  logic             w_ifu_pri;
  logic             w_gnt_lsu;
  logic             w_gnt_ifu;
  logic             w_gnt_any;
  logic [31:0]      w_sel_addr;
  logic [31:0]      w_st_data;
  logic [31:0]      w_shift;
  logic [31:0]      w_ld_ext;
  logic [31:0]      w_rsp_data;
  logic             w_rsp_live;

  always_comb begin
    case (lsu_size)
      2'b11:   w_lsu_err = (lsu_addr[1:0] != 2'b00);
      2'b10:   w_lsu_err = lsu_addr[0];
      2'b01:   w_lsu_err = 1'b0;
      default: w_lsu_err = 1'b1;
    endcase
  end

  assign w_ifu_err = |ifu_addr[1:0];

  // IFU wins only after MAX_WAIT consecutive stalled cycles; LSU otherwise.
  assign w_ifu_pri = (r_wait_cnt == WAIT_MAX);
  assign w_gnt_ifu = !RST && ifu_valid && (w_ifu_pri || !lsu_valid);
  assign w_gnt_lsu = !RST && lsu_valid && !(w_ifu_pri && ifu_valid);
  assign w_gnt_any = w_gnt_ifu || w_gnt_lsu;

  assign lsu_ready = w_gnt_lsu;
  assign ifu_ready = w_gnt_ifu;

  assign w_sel_addr = w_gnt_ifu ? ifu_addr : lsu_addr;

  always_comb begin
    case (lsu_size)
      2'b01:   w_st_data = {24'h000000, lsu_wdata[7:0]};
      2'b10:   w_st_data = {16'h0000, lsu_wdata[15:0]};
      default: w_st_data = lsu_wdata;
    endcase
  end

  // Without a grant the CCM pins keep their last value so the array sees no new access.
  assign mem_adr          = w_gnt_any ? {2'b00, w_sel_addr[31:2]} : r_mem_adr;
  assign mem_store_offset = w_gnt_any ? w_sel_addr[1:0] : r_mem_st_off;
  assign mem_store_type   = w_gnt_lsu ? lsu_size : (w_gnt_ifu ? 2'b11 : r_mem_st_type);
  assign mem_d            = w_gnt_lsu ? w_st_data : r_mem_d;
  assign mem_we           = w_gnt_lsu && lsu_we && !w_lsu_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mem_adr     <= '0;
      r_mem_d       <= '0;
      r_mem_st_type <= '0;
      r_mem_st_off  <= '0;
    end else if (w_gnt_any) begin
      r_mem_adr     <= mem_adr;
      r_mem_d       <= mem_d;
      r_mem_st_type <= mem_store_type;
      r_mem_st_off  <= mem_store_offset;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wait_cnt <= '0;
    end else if (!ifu_valid || w_gnt_ifu) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_MAX) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rsp_pend <= 1'b0;
      r_rsp_own  <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_ld_size  <= 2'b00;
      r_ld_uns   <= 1'b0;
      r_ld_off   <= 2'b00;
      r_rsp_st   <= 1'b0;
    end else begin
      r_rsp_pend <= w_gnt_any;
      if (w_gnt_any) begin
        r_rsp_own <= w_gnt_ifu;
        r_rsp_err <= w_gnt_ifu ? w_ifu_err : w_lsu_err;
        r_ld_size <= w_gnt_ifu ? 2'b11 : lsu_size;
        r_ld_uns  <= w_gnt_ifu ? 1'b1 : lsu_unsigned;
        r_ld_off  <= w_sel_addr[1:0];
        r_rsp_st  <= w_gnt_lsu && lsu_we;
      end
    end
  end

  assign w_shift = mem_q >> {r_ld_off, 3'b000};

  always_comb begin
    case (r_ld_size)
      2'b01:   w_ld_ext = {{24{!r_ld_uns && w_shift[7]}}, w_shift[7:0]};
      2'b10:   w_ld_ext = {{16{!r_ld_uns && w_shift[15]}}, w_shift[15:0]};
      default: w_ld_ext = w_shift;
    endcase
  end

  // Store responses ignore Q (the CCM drives 0 then); errors never carry data.
  assign w_rsp_data = (r_rsp_err || r_rsp_st) ? 32'h0 : w_ld_ext;
  // A grant taken just before RST rises must not produce a response.
  assign w_rsp_live = r_rsp_pend && !RST;

  assign lsu_rsp_valid = w_rsp_live && !r_rsp_own;
  assign lsu_rsp_rdata = lsu_rsp_valid ? w_rsp_data : 32'h0;
  assign lsu_rsp_err   = lsu_rsp_valid && r_rsp_err;

  assign ifu_rsp_valid = w_rsp_live && r_rsp_own;
  assign ifu_rsp_rdata = ifu_rsp_valid ? w_rsp_data : 32'h0;
  assign ifu_rsp_err   = ifu_rsp_valid && r_rsp_err;

endmodule

// File: tb/tb_ccm_port_arb.sv
// Bench for ccm_port_arb: byte-level reference memory and arbitration model feed
// per-requester expectation queues; a separate monitor checks responses.
module tb_ccm_port_arb;
  localparam int MAX_WAIT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        lsu_valid, lsu_ready, lsu_we, lsu_unsigned;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [1:0]  lsu_size;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rsp_rdata;
  logic        ifu_valid, ifu_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_rdata;
  logic [31:0] mem_adr, mem_d, mem_q;
  logic        mem_we;
  logic [1:0]  mem_store_type, mem_store_offset;

  always #5 CLK = ~CLK;

  ccm_port_arb #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_we(lsu_we),
    .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .lsu_wdata(lsu_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata), .ifu_rsp_err(ifu_rsp_err),
    .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we), .mem_store_type(mem_store_type),
    .mem_store_offset(mem_store_offset), .mem_q(mem_q)
  );

  // CCM array model: byte-lane writes via store_type/offset, Q=0 after a write.
  logic [31:0] ccm [0:65535];
  logic [31:0] ccm_q;
  assign mem_q = ccm_q;
  always @(posedge CLK) begin
    if (mem_we) begin
      case (mem_store_type)
        2'b01:   ccm[mem_adr[15:0]][{mem_store_offset, 3'b000} +: 8]  <= mem_d[7:0];
        2'b10:   ccm[mem_adr[15:0]][{mem_store_offset, 3'b000} +: 16] <= mem_d[15:0];
        default: ccm[mem_adr[15:0]] <= mem_d;
      endcase
      ccm_q <= 32'h0;
    end else begin
      ccm_q <= ccm[mem_adr[15:0]];
    end
  end

  typedef struct {
    int          stamp;
    logic [31:0] rdata;
    logic        err;
    logic        has_c;
    logic [31:0] c;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
    logic        has_c;
    logic [31:0] c;
  } req_t;

  exp_t lq[$];
  exp_t iq[$];
  req_t lsu_list[$];
  req_t ifu_list[$];
  logic [7:0] ref_mem [0:255];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic m_lsu_gnt = 1'b0;
  logic m_ifu_gnt = 1'b0;
  int   m_stall = 0;
  logic cur_lsu_has_c = 1'b0, cur_ifu_has_c = 1'b0;
  logic [31:0] cur_lsu_c = 32'h0, cur_ifu_c = 32'h0;
  logic log_en = 1'b0;
  int   gnt_log[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
  endtask

  function automatic int nbytes_of(input logic [1:0] s);
    return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : (s == 2'd3) ? 4 : 0;
  endfunction

  function automatic logic lsu_err_of(input logic [1:0] s, input logic [31:0] a);
    int n;
    n = nbytes_of(s);
    return (n == 0) || ((a % n) != 0);
  endfunction

  function automatic logic [31:0] load_val(input logic [7:0] a, input int n, input logic uns);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[8'(a + k)]) << (8 * k));
    if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Reference arbitration and scoreboard push, evaluated mid-cycle.
  always @(negedge CLK) begin : model_chk
    logic lg, ig, xe;
    exp_t e;
    int   n;
    lg = 1'b0;
    ig = 1'b0;
    if (RST) begin
      m_stall = 0;
      chk("mem_we_in_rst", mem_we, 1'b0);
    end else begin
      ig = ifu_valid && (m_stall >= MAX_WAIT || !lsu_valid);
      lg = lsu_valid && !ig;
      m_stall = (ifu_valid && !ig) ? m_stall + 1 : 0;
    end
    chk("lsu_ready", lsu_ready, lg);
    chk("ifu_ready", ifu_ready, ig);
    if (log_en) gnt_log.push_back(lsu_ready ? 1 : (ifu_ready ? 2 : 0));
    if (lg) begin
      n  = nbytes_of(lsu_size);
      xe = lsu_err_of(lsu_size, lsu_addr);
      chk("mem_adr_lsu", mem_adr, lsu_addr >> 2);
      chk("mem_store_type", mem_store_type, lsu_size);
      chk("mem_store_offset", mem_store_offset, lsu_addr % 4);
      chk("mem_we_lsu", mem_we, lsu_we && !xe);
      e.stamp = cyc;
      e.err   = xe;
      e.has_c = cur_lsu_has_c;
      e.c     = cur_lsu_c;
      e.rdata = (xe || lsu_we) ? 32'h0 : load_val(lsu_addr[7:0], n, lsu_unsigned);
      if (lsu_we && !xe)
        for (int k = 0; k < n; k++) ref_mem[8'(lsu_addr[7:0] + k)] = lsu_wdata[8 * k +: 8];
      lq.push_back(e);
    end else if (!RST) begin
      chk("mem_we_no_lsu", mem_we, 1'b0);
    end
    if (ig) begin
      xe = (ifu_addr % 4) != 0;
      chk("mem_adr_ifu", mem_adr, ifu_addr >> 2);
      e.stamp = cyc;
      e.err   = xe;
      e.has_c = cur_ifu_has_c;
      e.c     = cur_ifu_c;
      e.rdata = xe ? 32'h0 : load_val(ifu_addr[7:0], 4, 1'b1);
      iq.push_back(e);
    end
    m_lsu_gnt = lg;
    m_ifu_gnt = ig;
  end

  // Response monitor: an entry granted in cycle N is due in cycle N+1.
  always @(negedge CLK) begin : monitor
    logic lx, ix;
    exp_t e;
    if (RST) begin
      if (lq.size() > 0 && lq[0].stamp == cyc - 1) void'(lq.pop_front());
      if (iq.size() > 0 && iq[0].stamp == cyc - 1) void'(iq.pop_front());
      chk("lsu_rsp_valid_rst", lsu_rsp_valid, 1'b0);
      chk("ifu_rsp_valid_rst", ifu_rsp_valid, 1'b0);
    end else begin
      lx = lq.size() > 0 && lq[0].stamp == cyc - 1;
      ix = iq.size() > 0 && iq[0].stamp == cyc - 1;
      chk("lsu_rsp_valid", lsu_rsp_valid, lx);
      chk("ifu_rsp_valid", ifu_rsp_valid, ix);
      if (lx) begin
        e = lq.pop_front();
        chk("lsu_rsp_rdata", lsu_rsp_rdata, e.rdata);
        chk("lsu_rsp_err", lsu_rsp_err, e.err);
        if (e.has_c) chk("lsu_rdata_directed", lsu_rsp_rdata, e.c);
      end
      if (ix) begin
        e = iq.pop_front();
        chk("ifu_rsp_rdata", ifu_rsp_rdata, e.rdata);
        chk("ifu_rsp_err", ifu_rsp_err, e.err);
        if (e.has_c) chk("ifu_rdata_directed", ifu_rsp_rdata, e.c);
      end
    end
  end

  function automatic req_t mk_l(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic hc, input logic [31:0] c);
    req_t r;
    r.we = we; r.size = sz; r.uns = uns; r.addr = a; r.wdata = wd;
    r.gap = 0; r.has_c = hc; r.c = c;
    return r;
  endfunction

  function automatic req_t mk_i(input logic [31:0] a, input logic hc, input logic [31:0] c);
    return mk_l(1'b0, 2'd3, 1'b1, a, 32'h0, hc, c);
  endfunction

  // Drivers: called just after a posedge; return just after the posedge ending the grant cycle.
  task automatic lsu_go(input req_t r);
    int t;
    if (r.gap > 0) begin
      lsu_valid = 1'b0;
      repeat (r.gap) @(posedge CLK);
      #1;
    end
    lsu_valid = 1'b1; lsu_we = r.we; lsu_size = r.size; lsu_unsigned = r.uns;
    lsu_addr = r.addr; lsu_wdata = r.wdata;
    cur_lsu_has_c = r.has_c; cur_lsu_c = r.c;
    t = 0;
    do begin
      @(posedge CLK);
      t++;
    end while (!m_lsu_gnt && t < 60);
    chk("lsu_grant_in_budget", m_lsu_gnt, 1'b1);
    #1;
  endtask

  task automatic ifu_go(input req_t r);
    int t;
    if (r.gap > 0) begin
      ifu_valid = 1'b0;
      repeat (r.gap) @(posedge CLK);
      #1;
    end
    ifu_valid = 1'b1; ifu_addr = r.addr;
    cur_ifu_has_c = r.has_c; cur_ifu_c = r.c;
    t = 0;
    do begin
      @(posedge CLK);
      t++;
    end while (!m_ifu_gnt && t < 60);
    chk("ifu_grant_in_budget", m_ifu_gnt, 1'b1);
    #1;
  endtask

  task automatic run_lsu();
    while (lsu_list.size() > 0) lsu_go(lsu_list.pop_front());
    lsu_valid = 1'b0;
  endtask

  task automatic run_ifu();
    while (ifu_list.size() > 0) ifu_go(ifu_list.pop_front());
    ifu_valid = 1'b0;
  endtask

  task automatic run_both();
    fork
      run_lsu();
      run_ifu();
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pat [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    req_t r;
    for (int i = 0; i < 65536; i++) ccm[i] = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ccm_q = 32'h0;
    RST = 1'b1;
    lsu_valid = 1'b0; lsu_we = 1'b0; lsu_size = 2'd3; lsu_unsigned = 1'b0;
    lsu_addr = 32'h0; lsu_wdata = 32'h0; ifu_valid = 1'b0; ifu_addr = 32'h0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
    chk("rst_lsu_rsp_rdata", lsu_rsp_rdata, 32'h0);
    chk("rst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
    @(posedge CLK);
    #1;

    // Word, byte and half loads; byte store merges into the word.
    lsu_list.push_back(mk_l(1, 2'd3, 0, 32'h40, 32'hDEADBEEF, 0, 0));
    lsu_list.push_back(mk_l(0, 2'd3, 0, 32'h40, 0, 1, 32'hDEADBEEF));
    lsu_list.push_back(mk_l(0, 2'd1, 0, 32'h43, 0, 1, 32'hFFFFFFDE));
    lsu_list.push_back(mk_l(0, 2'd1, 1, 32'h43, 0, 1, 32'h000000DE));
    lsu_list.push_back(mk_l(0, 2'd2, 0, 32'h42, 0, 1, 32'hFFFFDEAD));
    lsu_list.push_back(mk_l(1, 2'd1, 0, 32'h41, 32'h00000055, 0, 0));
    lsu_list.push_back(mk_l(0, 2'd3, 0, 32'h40, 0, 1, 32'hDEAD55EF));
    run_both();

    // Error cases leave memory unchanged.
    lsu_list.push_back(mk_l(0, 2'd3, 0, 32'h42, 0, 1, 32'h0));
    lsu_list.push_back(mk_l(1, 2'd2, 0, 32'h41, 32'h00001234, 1, 32'h0));
    lsu_list.push_back(mk_l(1, 2'd0, 0, 32'h40, 32'h11111111, 1, 32'h0));
    lsu_list.push_back(mk_l(0, 2'd3, 0, 32'h40, 0, 1, 32'hDEAD55EF));
    run_both();
    ifu_list.push_back(mk_i(32'h06, 1, 32'h0));
    ifu_list.push_back(mk_i(32'h40, 1, 32'hDEAD55EF));
    run_both();

    // Contention: both held high from the same cycle.
    for (int i = 0; i < 10; i++) lsu_list.push_back(mk_l(0, 2'd3, 0, 32'h40, 0, 1, 32'hDEAD55EF));
    ifu_list.push_back(mk_i(32'h40, 1, 32'hDEAD55EF));
    ifu_list.push_back(mk_i(32'h44, 0, 0));
    gnt_log.delete();
    log_en = 1'b1;
    run_both();
    log_en = 1'b0;
    for (int i = 0; i < 10; i++)
      chk($sformatf("contention_grant_%0d", i), (gnt_log.size() > i) ? gnt_log[i] : -1, exp_pat[i]);

    // Reset the cycle after an IFU grant; LSU held valid across reset.
    ifu_go(mk_i(32'h40, 1, 32'hDEAD55EF));
    RST = 1'b1;
    ifu_valid = 1'b0;
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_size = 2'd3; lsu_addr = 32'h40;
    @(posedge CLK);
    #1 RST = 1'b0;
    fork
      lsu_go(mk_l(0, 2'd3, 0, 32'h40, 0, 1, 32'hDEAD55EF));
      begin
        @(negedge CLK);
        chk("post_rst_lsu_valid", lsu_rsp_valid, 1'b0);
        chk("post_rst_lsu_rdata", lsu_rsp_rdata, 32'h0);
        chk("post_rst_lsu_err", lsu_rsp_err, 1'b0);
        chk("post_rst_ifu_valid", ifu_rsp_valid, 1'b0);
        chk("post_rst_ifu_rdata", ifu_rsp_rdata, 32'h0);
        chk("post_rst_ifu_err", ifu_rsp_err, 1'b0);
      end
    join
    lsu_valid = 1'b0;

    // Randomized mixed traffic.
    for (int i = 0; i < 200; i++) begin
      r.we    = ($urandom_range(0, 2) == 0);
      r.size  = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      r.uns   = 1'($urandom_range(0, 1));
      r.addr  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (r.size == 2'd3) r.addr = r.addr & ~32'h3;
        if (r.size == 2'd2) r.addr = r.addr & ~32'h1;
      end
      r.wdata = $urandom;
      r.gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      r.has_c = 1'b0;
      r.c     = 32'h0;
      lsu_list.push_back(r);
    end
    for (int i = 0; i < 120; i++) begin
      r = mk_i(32'($urandom_range(0, 255)), 0, 0);
      if ($urandom_range(0, 5) != 0) r.addr = r.addr & ~32'h3;
      r.gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      ifu_list.push_back(r);
    end
    run_both();

    repeat (4) @(posedge CLK);
    #1;
    chk("lsu_queue_drained", lq.size(), 0);
    chk("ifu_queue_drained", iq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
